offchip_mem_responder: RTL and testbench

// - Off-chip memory side of the LC3 data-cache miss/write path; sits directly downstream of the cache memory interface.
// - Answers the rrqst/rrdy/rdrdy/rdacpt block-read handshake and the wrqst/wacpt single-word write handshake.
// - Backs both handshakes with a word-addressed storage array and applies programmable access latency.
// - The shared 16-bit offdata bus is split into in, out and output-enable signals; tristating is done at the top level.

---
 rtl/lc3_offchip_pkg.sv | 20 ++
 rtl/offchip_sram.sv | 27 ++
 rtl/offchip_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_offchip_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_offchip_pkg.sv
// Shared types for the LC3 off-chip memory responder: FSM state encoding,
// block geometry and the 16-bit word type used on the offdata bus.
package lc3_offchip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_RDY  = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_WR_WAIT = 3'd5,
        ST_WR_ACK  = 3'd6
    } offmem_state_t;

    localparam int BLOCK_WORDS = 4;
    localparam int BEAT_W      = 2;

    typedef logic [15:0] word_t;

endpackage

// File: rtl/offchip_sram.sv
// Single-port synchronous word array with one write port and a registered,
// read-first output. Contents have no reset and survive the block's reset.
module offchip_sram
    import lc3_offchip_pkg::*;
#(
    parameter int AWIDTH = 10
) (
    input  logic              clock,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_addr,
    input  word_t             i_wdata,
    output word_t             o_rdata
);

    word_t r_mem [0:(1<<AWIDTH)-1];
    word_t r_rdata;

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/offchip_mem_responder.sv
// Off-chip memory model behind the LC3 data cache: serves 4-word block reads
// and single-word writes with programmable latency over a split offdata bus.
module offchip_mem_responder
    import lc3_offchip_pkg::*;
#(
    parameter int MEM_AWIDTH = 10,
    parameter int RD_LATENCY = 3,
    parameter int WR_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rrqst,
    input  logic        rdacpt,
    input  logic        wrqst,
    input  logic [15:0] offdata_in,
    output logic [15:0] offdata_out,
    output logic        offdata_oe,
    output logic        rrdy,
    output logic        rdrdy,
    output logic        wacpt,
    input  logic        init_we,
    input  logic [15:0] init_addr,
    input  logic [15:0] init_data
);

    localparam int CNT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    offmem_state_t          r_state;
    offmem_state_t          w_stateNext;
    logic [MEM_AWIDTH-1:0]  r_addr;
    logic [MEM_AWIDTH-1:0]  w_addrNext;
    word_t                  r_wdata;
    word_t                  w_wdataNext;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cntNext;
    logic [BEAT_W-1:0]      r_beat;
    logic [BEAT_W-1:0]      w_beatNext;
    logic                   r_beatValid;
    logic                   w_beatValidNext;

    logic                   w_memWe;
    logic [MEM_AWIDTH-1:0]  w_memAddr;
    word_t                  w_memWdata;
    word_t                  w_memRdata;
    logic                   w_unused;

    assign w_unused = &{1'b0, init_addr[15:MEM_AWIDTH]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_beat      <= '0;
            r_beatValid <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_addr      <= w_addrNext;
            r_wdata     <= w_wdataNext;
            r_cnt       <= w_cntNext;
            r_beat      <= w_beatNext;
            r_beatValid <= w_beatValidNext;
        end
    end

    // r_beatValid low marks the one cycle in which the array is still
    // fetching the word for a freshly advanced beat.
    always_comb begin
        w_stateNext     = r_state;
        w_addrNext      = r_addr;
        w_wdataNext     = r_wdata;
        w_cntNext       = r_cnt;
        w_beatNext      = r_beat;
        w_beatValidNext = r_beatValid;

        case (r_state)
            ST_IDLE: begin
                if (rrqst) begin
                    w_addrNext  = offdata_in[MEM_AWIDTH-1:0];
                    w_cntNext   = CNT_W'(RD_LATENCY - 1);
                    w_stateNext = ST_RD_WAIT;
                end else if (wrqst) begin
                    w_addrNext  = offdata_in[MEM_AWIDTH-1:0];
                    w_stateNext = ST_WR_DATA;
                end
            end
            ST_RD_WAIT: begin
                if (!rrqst) begin
                    w_stateNext = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_stateNext = ST_RD_RDY;
                end else begin
                    w_cntNext = r_cnt - CNT_W'(1);
                end
            end
            ST_RD_RDY: begin
                if (!rrqst) begin
                    w_beatNext      = '0;
                    w_beatValidNext = 1'b0;
                    w_stateNext     = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (!r_beatValid) begin
                    w_beatValidNext = 1'b1;
                end else if (rdacpt) begin
                    w_beatValidNext = 1'b0;
                    if (r_beat == BEAT_W'(BLOCK_WORDS - 1)) begin
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_beatNext = r_beat + BEAT_W'(1);
                    end
                end
            end
            ST_WR_DATA: begin
                if (!wrqst) begin
                    w_stateNext = ST_IDLE;
                end else begin
                    w_wdataNext = offdata_in;
                    w_cntNext   = CNT_W'(WR_LATENCY - 1);
                    w_stateNext = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (!wrqst) begin
                    w_stateNext = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_stateNext = ST_WR_ACK;
                end else begin
                    w_cntNext = r_cnt - CNT_W'(1);
                end
            end
            ST_WR_ACK: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // The single array port is shared: preload in IDLE, the committed write
    // on the last WR_WAIT cycle, and block-beat reads everywhere else.
    always_comb begin
        w_memWe    = 1'b0;
        w_memAddr  = {r_addr[MEM_AWIDTH-1:BEAT_W], r_beat};
        w_memWdata = r_wdata;
        if (r_state == ST_IDLE && init_we) begin
            w_memWe    = 1'b1;
            w_memAddr  = init_addr[MEM_AWIDTH-1:0];
            w_memWdata = init_data;
        end else if (r_state == ST_WR_WAIT && wrqst && r_cnt == '0) begin
            w_memWe   = 1'b1;
            w_memAddr = r_addr;
        end
    end

    offchip_sram #(
        .AWIDTH (MEM_AWIDTH)
    ) u_sram (
        .clock   (clock),
        .i_we    (w_memWe),
        .i_addr  (w_memAddr),
        .i_wdata (w_memWdata),
        .o_rdata (w_memRdata)
    );

    assign rrdy        = (r_state == ST_RD_RDY);
    assign offdata_oe  = (r_state == ST_RD_DATA);
    assign rdrdy       = offdata_oe && r_beatValid;
    assign wacpt       = (r_state == ST_WR_ACK);
    assign offdata_out = offdata_oe ? w_memRdata : 16'h0000;

endmodule

// File: tb/tb_offchip_mem_responder.sv
// Scoreboard bench for offchip_mem_responder: directed reads/writes push
// expected beats and acks; a negedge monitor pops and compares them.
module tb_offchip_mem_responder;

    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    logic        clock;
    logic        reset;
    logic        rrqst;
    logic        rdacpt;
    logic        wrqst;
    logic [15:0] offdata_in;
    logic [15:0] offdata_out;
    logic        offdata_oe;
    logic        rrdy;
    logic        rdrdy;
    logic        wacpt;
    logic        init_we;
    logic [15:0] init_addr;
    logic [15:0] init_data;

    typedef struct packed {
        logic        isWrite;
        logic [15:0] data;
    } sbEntry_t;

    sbEntry_t sb[$];
    int checks = 0;
    int errors = 0;

    offchip_mem_responder #(
        .MEM_AWIDTH (10),
        .RD_LATENCY (RD_LAT),
        .WR_LATENCY (WR_LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rrqst       (rrqst),
        .rdacpt      (rdacpt),
        .wrqst       (wrqst),
        .offdata_in  (offdata_in),
        .offdata_out (offdata_out),
        .offdata_oe  (offdata_oe),
        .rrdy        (rrdy),
        .rdrdy       (rdrdy),
        .wacpt       (wacpt),
        .init_we     (init_we),
        .init_addr   (init_addr),
        .init_data   (init_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input logic isW, input logic [15:0] data, input string name);
        sbEntry_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s unexpected actual=%h required=none", name, data);
        end else begin
            e = sb.pop_front();
            if (e.isWrite !== isW || e.data !== data) begin
                errors++;
                $display("[TB] FAIL %s actual=%b/%h required=%b/%h", name, isW, data, e.isWrite, e.data);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (rdrdy && rdacpt) checkOutput(1'b0, offdata_out, "read beat");
            if (wacpt) checkOutput(1'b1, 16'h0000, "write ack");
        end
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(posedge clock); #1;
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        @(posedge clock); #1;
        init_we   = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic [15:0] addr,
                                 input logic [15:0] e0, input logic [15:0] e1,
                                 input logic [15:0] e2, input logic [15:0] e3,
                                 input logic alsoWrite, input int stallBeat, input int stallCycles);
        logic [15:0] exp [4];
        int n;
        int idx;
        int stallLeft;
        int guard;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int i = 0; i < 4; i++) sb.push_back({1'b0, exp[i]});
        @(posedge clock); #1;
        rrqst      = 1'b1;
        wrqst      = alsoWrite;
        offdata_in = addr;
        @(posedge clock); #1;
        n = 0;
        while (!rrdy && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        checkVal({tag, " rrdy latency"}, 16'(n), 16'(RD_LAT));
        rrqst      = 1'b0;
        wrqst      = 1'b0;
        offdata_in = 16'h0000;
        idx = 0;
        stallLeft = stallCycles;
        guard = 0;
        while (idx < 4 && guard < 200) begin
            @(posedge clock); #1;
            guard++;
            if (rdrdy) begin
                if (idx == stallBeat && stallLeft > 0) begin
                    rdacpt = 1'b0;
                    checkVal({tag, " stalled beat"}, offdata_out, exp[idx]);
                    stallLeft--;
                end else begin
                    rdacpt = 1'b1;
                    idx++;
                end
            end else begin
                rdacpt = 1'b0;
            end
        end
        checkVal({tag, " beats accepted"}, 16'(idx), 16'd4);
        @(posedge clock); #1;
        rdacpt = 1'b0;
        checkVal({tag, " oe after block"}, {15'd0, offdata_oe}, 16'h0000);
    endtask

    task automatic doWrite(input string tag, input logic [15:0] addr, input logic [15:0] data);
        int n;
        sb.push_back({1'b1, 16'h0000});
        @(posedge clock); #1;
        wrqst      = 1'b1;
        offdata_in = addr;
        @(posedge clock); #1;
        offdata_in = data;
        n = 0;
        while (!wacpt && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        checkVal({tag, " wacpt latency"}, 16'(n), 16'(WR_LAT + 1));
        wrqst      = 1'b0;
        offdata_in = 16'h0000;
        @(posedge clock); #1;
        checkVal({tag, " wacpt width"}, {15'd0, wacpt}, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b0; rrqst = 1'b0; rdacpt = 1'b0; wrqst = 1'b0;
        offdata_in = '0; init_we = 1'b0; init_addr = '0; init_data = '0;
        repeat (3) @(negedge clock);
        checkVal("reset flags", {12'd0, rrdy, rdrdy, wacpt, offdata_oe}, 16'h0000);
        checkVal("reset data", offdata_out, 16'h0000);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            preload(16'h0040 + 16'(i), 16'hA000 + 16'(i));
            preload(16'h0000 + 16'(i), 16'h1000 + 16'(i));
            preload(16'h0020 + 16'(i), 16'h2020 + 16'(i));
        end
        preload(16'h0010, 16'hC010);
        preload(16'h0011, 16'hC011);
        preload(16'h0012, 16'hC012);
        preload(16'h0013, 16'hC013);
        preload(16'h0004, 16'h4004);
        preload(16'h0005, 16'h5555);
        preload(16'h0006, 16'h6006);
        preload(16'h0007, 16'h7007);

        applyStimulus("blk40", 16'h0042, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1'b0, -1, 0);

        doWrite("wr11", 16'h0011, 16'hBEEF);

        // Write to 0x12 abandoned mid-latency must leave the array untouched.
        @(posedge clock); #1;
        wrqst = 1'b1; offdata_in = 16'h0012;
        @(posedge clock); #1;
        offdata_in = 16'hDEAD;
        @(posedge clock); #1;
        wrqst = 1'b0; offdata_in = 16'h0000;
        repeat (4) @(posedge clock);

        applyStimulus("blk10", 16'h0010, 16'hC010, 16'hBEEF, 16'hC012, 16'hC013, 1'b0, -1, 0);

        applyStimulus("prio", 16'h0020, 16'h2020, 16'h2021, 16'h2022, 16'h2023, 1'b1, -1, 0);
        applyStimulus("prio reread", 16'h0022, 16'h2020, 16'h2021, 16'h2022, 16'h2023, 1'b0, -1, 0);

        @(posedge clock); #1;
        wrqst = 1'b1; offdata_in = 16'h0005;
        @(posedge clock); #1;
        offdata_in = 16'h1234;
        @(posedge clock); #1;
        reset = 1'b0; wrqst = 1'b0; offdata_in = 16'h0000;
        @(negedge clock);
        checkVal("midwrite reset flags", {12'd0, rrdy, rdrdy, wacpt, offdata_oe}, 16'h0000);
        checkVal("midwrite reset data", offdata_out, 16'h0000);
        @(negedge clock);
        reset = 1'b1;
        applyStimulus("blk04", 16'h0005, 16'h4004, 16'h5555, 16'h6006, 16'h7007, 1'b0, -1, 0);

        applyStimulus("alias402", 16'h0402, 16'h1000, 16'h1001, 16'h1002, 16'h1003, 1'b0, -1, 0);

        applyStimulus("stall", 16'h0041, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1'b0, 2, 5);

        repeat (3) @(posedge clock);
        checkVal("scoreboard drained", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
